// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// supported opcodes and the ALU operand/operation select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_FOUR = 2'b01;
    localparam logic [1:0] B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus memory port (slave).
interface multicycle_control_if #(
    parameter int unsigned RETIRE_W = 32
);
    logic [6:0]          opcode;
    logic                mem_ready;
    logic                branch_taken;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_wr;
    logic                pc_wr;
    logic                pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                reg_wr;
    logic                mem_to_reg;
    logic                illegal;
    logic                instr_done;
    logic [RETIRE_W-1:0] instret;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_wr, mem_to_reg, illegal, instr_done, instret
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_wr, mem_to_reg, illegal, instr_done, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch..writeback,
// arbitrates the shared memory port and counts retired instructions.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    multicycle_control_if.master bus_io
);

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] instret_q;

    logic       mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_wr, mem_to_reg, illegal, instr_done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                instret_q <= instret_q + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = B_RS2;
        alu_op     = ALU_ADD;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = B_FOUR;
                if (bus_io.mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = B_IMM;
                case (bus_io.opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAddr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                state_d   = (bus_io.opcode == OP_LOAD) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus_io.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus_io.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = B_RS2;
                alu_op    = ALU_R;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                alu_op    = ALU_I;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = B_RS2;
                alu_op     = ALU_BR;
                pc_src     = 1'b1;
                pc_wr      = bus_io.branch_taken;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset silences every output in the same cycle, dropping any pending request.
    assign bus_io.mem_req    = n_rst & mem_req;
    assign bus_io.mem_we     = n_rst & mem_we;
    assign bus_io.iord       = n_rst & iord;
    assign bus_io.ir_wr      = n_rst & ir_wr;
    assign bus_io.pc_wr      = n_rst & pc_wr;
    assign bus_io.pc_src     = n_rst & pc_src;
    assign bus_io.alu_src_a  = n_rst & alu_src_a;
    assign bus_io.alu_src_b  = n_rst ? alu_src_b : 2'b00;
    assign bus_io.alu_op     = n_rst ? alu_op : 2'b00;
    assign bus_io.reg_wr     = n_rst & reg_wr;
    assign bus_io.mem_to_reg = n_rst & mem_to_reg;
    assign bus_io.illegal    = n_rst & illegal;
    assign bus_io.instr_done = n_rst & instr_done;
    assign bus_io.instret    = n_rst ? instret_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of per-cycle vectors checked through a
// scoreboard queue, plus a narrow-counter instance for the wrap case.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic n_rst;
    logic n_rst2;

    always #5 clk = ~clk;

    multicycle_control_if #(.RETIRE_W(32)) bus ();
    multicycle_control_if #(.RETIRE_W(2))  bus2 ();

    multicycle_control #(.RETIRE_W(32)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .bus_io (bus)
    );

    multicycle_control #(.RETIRE_W(2)) dut2 (
        .clk    (clk),
        .n_rst  (n_rst2),
        .bus_io (bus2)
    );

    typedef enum {
        EReset, EFetch, EDecode, EDecodeBad, EMemAddr, EMemRd, EMemWb, EMemWr,
        EExecR, EExecI, EAluWb, EBranch
    } est_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       illegal;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        rdy;
        logic        tk;
        est_t        st;
        logic [31:0] inst;
    } vec_t;

    typedef struct {
        outs_t       o;
        logic [31:0] inst;
        int          idx;
    } exp_t;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] L = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011;
    localparam logic [6:0] B = 7'b1100011;
    localparam logic [6:0] X = 7'b1110011;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(logic r, logic [6:0] op, logic rdy, logic tk, est_t st,
                                logic [31:0] inst);
        vec_t v;
        v.rst_n = r; v.op = op; v.rdy = rdy; v.tk = tk; v.st = st; v.inst = inst;
        vecs.push_back(v);
    endfunction

    // Expected outputs for each state, written directly from the state table.
    function automatic outs_t exp_out(est_t st, logic rdy, logic tk);
        outs_t o;
        o = '0;
        case (st)
            EFetch:     begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_wr = rdy; o.pc_wr = rdy; end
            EDecode:    o.alu_src_b = 2'b10;
            EDecodeBad: begin o.alu_src_b = 2'b10; o.illegal = 1; end
            EMemAddr:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            EMemRd:     begin o.mem_req = 1; o.iord = 1; end
            EMemWb:     begin o.reg_wr = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            EMemWr:     begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.instr_done = rdy; end
            EExecR:     begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            EExecI:     begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
            EAluWb:     begin o.reg_wr = 1; o.instr_done = 1; end
            EBranch:    begin
                o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 1; o.pc_wr = tk;
                o.instr_done = 1;
            end
            default:    o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t get_out();
        outs_t o;
        o.mem_req = bus.mem_req;     o.mem_we = bus.mem_we;         o.iord = bus.iord;
        o.ir_wr = bus.ir_wr;         o.pc_wr = bus.pc_wr;           o.pc_src = bus.pc_src;
        o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;   o.alu_op = bus.alu_op;
        o.reg_wr = bus.reg_wr;       o.mem_to_reg = bus.mem_to_reg; o.illegal = bus.illegal;
        o.instr_done = bus.instr_done;
        return o;
    endfunction

    initial begin
        exp_t        e;
        outs_t       act;
        logic [1:0]  wexp;

        // reset held with mem_ready high
        repeat (3) add(0, R, 1, 0, EReset, 0);
        // RTYPE, zero wait
        add(1, R, 1, 0, EFetch, 0);  add(1, R, 1, 0, EDecode, 0);
        add(1, R, 1, 0, EExecR, 0);  add(1, R, 1, 0, EAluWb, 0);
        // LOAD with two wait cycles in MEM_RD
        add(1, L, 1, 0, EFetch, 1);  add(1, L, 1, 0, EDecode, 1);
        add(1, L, 1, 0, EMemAddr, 1);
        add(1, L, 0, 0, EMemRd, 1);  add(1, L, 0, 0, EMemRd, 1);  add(1, L, 1, 0, EMemRd, 1);
        add(1, L, 0, 0, EMemWb, 1);
        // STORE with one wait
        add(1, S, 1, 0, EFetch, 2);  add(1, S, 1, 0, EDecode, 2);  add(1, S, 1, 0, EMemAddr, 2);
        add(1, S, 0, 0, EMemWr, 2);  add(1, S, 1, 0, EMemWr, 2);
        // BRANCH taken, then not taken
        add(1, B, 1, 1, EFetch, 3);  add(1, B, 1, 1, EDecode, 3);  add(1, B, 0, 1, EBranch, 3);
        add(1, B, 1, 0, EFetch, 4);  add(1, B, 1, 0, EDecode, 4);  add(1, B, 1, 0, EBranch, 4);
        // ITYPE
        add(1, I, 1, 0, EFetch, 5);  add(1, I, 1, 0, EDecode, 5);
        add(1, I, 1, 0, EExecI, 5);  add(1, I, 1, 0, EAluWb, 5);
        // fetch wait, then illegal opcode
        add(1, X, 0, 0, EFetch, 6);  add(1, X, 1, 0, EFetch, 6);  add(1, X, 1, 0, EDecodeBad, 6);
        // STORE cut short by reset during a MEM_WR wait cycle
        add(1, S, 1, 0, EFetch, 6);  add(1, S, 1, 0, EDecode, 6);  add(1, S, 1, 0, EMemAddr, 6);
        add(1, S, 0, 0, EMemWr, 6);  add(0, S, 1, 0, EReset, 0);
        add(1, S, 0, 0, EFetch, 0);  add(1, S, 1, 0, EFetch, 0);  add(1, S, 1, 0, EDecode, 0);

        n_rst  = 1'b0;
        n_rst2 = 1'b0;
        bus.opcode = R; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
        bus2.opcode = R; bus2.mem_ready = 1'b1; bus2.branch_taken = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            n_rst            = vecs[i].rst_n;
            bus.opcode       = vecs[i].op;
            bus.mem_ready    = vecs[i].rdy;
            bus.branch_taken = vecs[i].tk;
            e.o    = exp_out(vecs[i].st, vecs[i].rdy, vecs[i].tk);
            e.inst = vecs[i].inst;
            e.idx  = i;
            sb.push_back(e);
            #2;
            e   = sb.pop_front();
            act = get_out();
            total++;
            if (act !== e.o) begin
                bad++;
                $display("FAIL outputs row %0d: got %h want %h", e.idx, act, e.o);
            end
            total++;
            if (bus.instret !== e.inst) begin
                bad++;
                $display("FAIL instret row %0d: got %0d want %0d", e.idx, bus.instret, e.inst);
            end
        end

        // 2-bit counter retires four RTYPEs: 1, 2, 3, then wraps to 0
        @(negedge clk);
        n_rst2 = 1'b1;
        wexp   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            #2;
            wexp = wexp + 2'd1;
            total++;
            if (bus2.instret !== wexp) begin
                bad++;
                $display("FAIL wrap step %0d: got %0d want %0d", k, bus2.instret, wexp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
